match_ctrl: RTL and testbench

Game-level sequencer for the Pong datapath. It owns the match state machine (idle, serve, play, point, game over) and keeps the two scores. It produces the up/down commands consumed by the paddle block, either from synchronised player buttons or from a CPU opponent for paddle 2. It also issues recenter/reset pulses and the run enable to the paddle and ball logic.

---
 rtl/match_ctrl.sv | 177 +++++++++++++++++
 tb/tb_match_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// Pong match sequencer: serve/play/point/over FSM, scores,
// paddle commands from synchronised buttons or the CPU opponent.
module match_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7,
  parameter int PAD_HEIGHT   = 72,
  parameter int AI_DEADBAND  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       start,
  input  logic       btn_up1,
  input  logic       btn_down1,
  input  logic       btn_up2,
  input  logic       btn_down2,
  input  logic       ai_mode,
  input  logic [9:0] ball_y,
  input  logic [9:0] pad2_t,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       up1,
  output logic       down1,
  output logic       up2,
  output logic       down2,
  output logic       pad_reset,
  output logic       ball_reset,
  output logic       ball_en,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic [1:0] winner
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);
  localparam logic [15:0] POINT_LAST = 16'(POINT_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  logic        frame_tick;
  logic        start_q;
  logic        start_edge;
  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  cmd_q;
  logic        ai_up;
  logic        ai_dn;
  logic [10:0] centre;
  logic [10:0] ball_w;
  logic        ai_up_n;
  logic        ai_dn_n;
  logic        pass;
  logic [15:0] cnt;

  assign frame_tick = (y == 10'd481) && (x == 10'd0);
  assign start_edge = start & ~start_q;

  // 11-bit arithmetic so a paddle near the bottom cannot wrap
  assign centre  = {1'b0, pad2_t} + 11'(PAD_HEIGHT / 2);
  assign ball_w  = {1'b0, ball_y};
  assign ai_up_n = (ball_w + 11'(AI_DEADBAND)) < centre;
  assign ai_dn_n = ball_w > (centre + 11'(AI_DEADBAND));

  assign pass    = (state == S_SERVE) || (state == S_PLAY);
  assign ball_en = (state == S_PLAY);

  assign up1   = pass & cmd_q[3];
  assign down1 = pass & cmd_q[2];
  assign up2   = pass & (ai_mode ? ai_up : cmd_q[1]);
  assign down2 = pass & (ai_mode ? ai_dn : cmd_q[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      sync1   <= '0;
      sync2   <= '0;
      cmd_q   <= '0;
      ai_up   <= 1'b0;
      ai_dn   <= 1'b0;
    end else begin
      start_q <= start;
      sync1   <= {btn_up1, btn_down1, btn_up2, btn_down2};
      sync2   <= sync1;
      cmd_q   <= {sync2[3] & ~sync2[2], sync2[2] & ~sync2[3],
                  sync2[1] & ~sync2[0], sync2[0] & ~sync2[1]};
      if (frame_tick) begin
        ai_up <= ai_up_n;
        ai_dn <= ai_dn_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      score1     <= '0;
      score2     <= '0;
      winner     <= '0;
      pad_reset  <= 1'b0;
      ball_reset <= 1'b0;
    end else begin
      pad_reset  <= 1'b0;
      ball_reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state      <= S_SERVE;
            cnt        <= '0;
            pad_reset  <= 1'b1;
            ball_reset <= 1'b1;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            if (cnt == SERVE_LAST) begin
              state <= S_PLAY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_PLAY: begin
          if (miss_l | miss_r) begin
            state <= S_POINT;
            cnt   <= '0;
            if (miss_l && !miss_r && score1 != WIN)
              score1 <= score1 + 4'd1;
            if (miss_r && !miss_l && score2 != WIN)
              score2 <= score2 + 4'd1;
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            if (cnt == POINT_LAST) begin
              cnt <= '0;
              if (score1 == WIN) begin
                state  <= S_OVER;
                winner <= 2'b01;
              end else if (score2 == WIN) begin
                state  <= S_OVER;
                winner <= 2'b10;
              end else begin
                state      <= S_SERVE;
                pad_reset  <= 1'b1;
                ball_reset <= 1'b1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_OVER: begin
          if (start_edge) begin
            state      <= S_SERVE;
            cnt        <= '0;
            score1     <= '0;
            score2     <= '0;
            winner     <= '0;
            pad_reset  <= 1'b1;
            ball_reset <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: match flow, scoring, win,
// button pipeline scoreboard and CPU paddle decisions.
module tb_match_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       start;
  logic       btn_up1, btn_down1, btn_up2, btn_down2;
  logic       ai_mode;
  logic [9:0] ball_y, pad2_t;
  logic       miss_l, miss_r;
  logic       up1, down1, up2, down2;
  logic       pad_reset, ball_reset, ball_en;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic [1:0] winner;

  int vecs = 0;
  int errs = 0;
  int exp_s1 = 0;
  logic [3:0] sb[$];

  match_ctrl dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .start(start),
    .btn_up1(btn_up1), .btn_down1(btn_down1),
    .btn_up2(btn_up2), .btn_down2(btn_down2),
    .ai_mode(ai_mode), .ball_y(ball_y), .pad2_t(pad2_t),
    .miss_l(miss_l), .miss_r(miss_r),
    .up1(up1), .down1(down1), .up2(up2), .down2(down2),
    .pad_reset(pad_reset), .ball_reset(ball_reset),
    .ball_en(ball_en), .score1(score1), .score2(score2),
    .state(state), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      y = 10'd481; x = 10'd0;
      step();
      y = 10'd0; x = 10'd5;
      step();
    end
  endtask

  task automatic miss(input logic l, input logic r);
    miss_l = l; miss_r = r;
    step();
    miss_l = 1'b0; miss_r = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vecs++;
    if ({state, score1, score2, winner, ball_en, pad_reset, ball_reset,
         up1, down1, up2, down2} !== 22'd0) begin
      errs++;
      $display("FAIL reset_outputs: got state=%0d s1=%0d s2=%0d w=%0d en=%0d want all 0",
               state, score1, score2, winner, ball_en);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    vecs++;
    if (state !== 3'd1 || pad_reset !== 1'b1 || ball_reset !== 1'b1) begin
      errs++;
      $display("FAIL start_serve: got state=%0d pr=%0d br=%0d want 1 1 1",
               state, pad_reset, ball_reset);
    end
    start = 1'b0;
    step();
    vecs++;
    if (pad_reset !== 1'b0 || ball_reset !== 1'b0 || score1 !== 4'd0 || score2 !== 4'd0) begin
      errs++;
      $display("FAIL start_pulse_len: got pr=%0d br=%0d s1=%0d s2=%0d want 0 0 0 0",
               pad_reset, ball_reset, score1, score2);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    vecs++;
    if (state !== 3'd1 || pad_reset !== 1'b0) begin
      errs++;
      $display("FAIL start_ignored_serve: got state=%0d pr=%0d want 1 0", state, pad_reset);
    end
  endtask

  task automatic test_serve();
    ticks(59);
    vecs++;
    if (state !== 3'd1 || ball_en !== 1'b0) begin
      errs++;
      $display("FAIL serve_59: got state=%0d en=%0d want 1 0", state, ball_en);
    end
    ticks(1);
    vecs++;
    if (state !== 3'd2 || ball_en !== 1'b1) begin
      errs++;
      $display("FAIL serve_60: got state=%0d en=%0d want 2 1", state, ball_en);
    end
  endtask

  task automatic test_miss();
    miss(1'b1, 1'b0);
    exp_s1 = 1;
    vecs++;
    if (score1 !== 4'd1 || score2 !== 4'd0 || state !== 3'd3 || ball_en !== 1'b0) begin
      errs++;
      $display("FAIL miss_l: got s1=%0d s2=%0d state=%0d en=%0d want 1 0 3 0",
               score1, score2, state, ball_en);
    end
    miss(1'b0, 1'b1);
    vecs++;
    if (score2 !== 4'd0) begin
      errs++;
      $display("FAIL miss_in_point: got s2=%0d want 0", score2);
    end
    ticks(89);
    vecs++;
    if (state !== 3'd3) begin
      errs++;
      $display("FAIL point_89: got state=%0d want 3", state);
    end
    ticks(1);
    vecs++;
    if (state !== 3'd1 || pad_reset !== 1'b0) begin
      errs++;
      $display("FAIL point_90: got state=%0d pr=%0d want 1 0", state, pad_reset);
    end
    ticks(60);
    miss(1'b1, 1'b1);
    vecs++;
    if (score1 !== 4'd1 || score2 !== 4'd0 || state !== 3'd3) begin
      errs++;
      $display("FAIL miss_both: got s1=%0d s2=%0d state=%0d want 1 0 3",
               score1, score2, state);
    end
    y = 10'd481; x = 10'd0;
    repeat (89) begin
      step();
      y = 10'd0; x = 10'd5;
      step();
      y = 10'd481; x = 10'd0;
    end
    step();
    vecs++;
    if (state !== 3'd1 || pad_reset !== 1'b1 || ball_reset !== 1'b1) begin
      errs++;
      $display("FAIL serve_pulse: got state=%0d pr=%0d br=%0d want 1 1 1",
               state, pad_reset, ball_reset);
    end
    y = 10'd0; x = 10'd5;
    step();
    ticks(60);
  endtask

  task automatic test_buttons();
    logic [3:0] stim [16];
    logic [3:0] got, e, s;
    stim = '{4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000,
             4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b0001,
             4'b0011, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 16; i++) begin
      s = stim[i];
      {btn_up1, btn_down1, btn_up2, btn_down2} = s;
      sb.push_back({s[3] & ~s[2], s[2] & ~s[3], s[1] & ~s[0], s[0] & ~s[1]});
      step();
      if (sb.size() == 3) begin
        e = sb.pop_front();
        got = {up1, down1, up2, down2};
        vecs++;
        if (got !== e) begin
          errs++;
          $display("FAIL btn_pipe[%0d]: got %b want %b", i, got, e);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_ai();
    ai_mode = 1'b1; pad2_t = 10'd200; ball_y = 10'd240;
    ticks(1);
    vecs++;
    if (up2 !== 1'b0 || down2 !== 1'b0) begin
      errs++;
      $display("FAIL ai_hold_240: got up=%0d dn=%0d want 0 0", up2, down2);
    end
    ball_y = 10'd100;
    step();
    vecs++;
    if (up2 !== 1'b0) begin
      errs++;
      $display("FAIL ai_pre_tick_up: got up=%0d want 0", up2);
    end
    ticks(1);
    vecs++;
    if (up2 !== 1'b1 || down2 !== 1'b0) begin
      errs++;
      $display("FAIL ai_up: got up=%0d dn=%0d want 1 0", up2, down2);
    end
    ball_y = 10'd300;
    step();
    vecs++;
    if (up2 !== 1'b1 || down2 !== 1'b0) begin
      errs++;
      $display("FAIL ai_pre_tick_dn: got up=%0d dn=%0d want 1 0", up2, down2);
    end
    ticks(1);
    vecs++;
    if (up2 !== 1'b0 || down2 !== 1'b1) begin
      errs++;
      $display("FAIL ai_down: got up=%0d dn=%0d want 0 1", up2, down2);
    end
    ball_y = 10'd228;
    ticks(1);
    vecs++;
    if (up2 !== 1'b0 || down2 !== 1'b0) begin
      errs++;
      $display("FAIL ai_edge_228: got up=%0d dn=%0d want 0 0", up2, down2);
    end
    ball_y = 10'd227;
    ticks(1);
    vecs++;
    if (up2 !== 1'b1) begin
      errs++;
      $display("FAIL ai_edge_227: got up=%0d want 1", up2);
    end
    ball_y = 10'd244;
    ticks(1);
    vecs++;
    if (up2 !== 1'b0 || down2 !== 1'b0) begin
      errs++;
      $display("FAIL ai_edge_244: got up=%0d dn=%0d want 0 0", up2, down2);
    end
    ball_y = 10'd245;
    ticks(1);
    vecs++;
    if (down2 !== 1'b1) begin
      errs++;
      $display("FAIL ai_edge_245: got dn=%0d want 1", down2);
    end
    ai_mode = 1'b0;
  endtask

  task automatic test_point_gate();
    miss(1'b0, 1'b1);
    vecs++;
    if (score2 !== 4'd1 || state !== 3'd3) begin
      errs++;
      $display("FAIL miss_r: got s2=%0d state=%0d want 1 3", score2, state);
    end
    btn_up1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vecs++;
      if (up1 !== 1'b0) begin
        errs++;
        $display("FAIL point_gate[%0d]: got up1=%0d want 0", i, up1);
      end
    end
    btn_up1 = 1'b0;
    ticks(90);
  endtask

  task automatic test_win();
    while (exp_s1 < 6) begin
      ticks(60);
      miss(1'b1, 1'b0);
      exp_s1++;
      vecs++;
      if (score1 !== 4'(exp_s1)) begin
        errs++;
        $display("FAIL score_run: got s1=%0d want %0d", score1, exp_s1);
      end
      ticks(90);
    end
    ticks(60);
    miss(1'b1, 1'b0);
    vecs++;
    if (score1 !== 4'd7 || score2 !== 4'd1) begin
      errs++;
      $display("FAIL score_7: got s1=%0d s2=%0d want 7 1", score1, score2);
    end
    ticks(90);
    vecs++;
    if (state !== 3'd4 || winner !== 2'b01 || pad_reset !== 1'b0 || ball_en !== 1'b0) begin
      errs++;
      $display("FAIL over: got state=%0d w=%0d pr=%0d en=%0d want 4 1 0 0",
               state, winner, pad_reset, ball_en);
    end
    ticks(3);
    vecs++;
    if (state !== 3'd4 || score1 !== 4'd7) begin
      errs++;
      $display("FAIL over_hold: got state=%0d s1=%0d want 4 7", state, score1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    vecs++;
    if (state !== 3'd1 || score1 !== 4'd0 || score2 !== 4'd0 ||
        winner !== 2'b00 || pad_reset !== 1'b1) begin
      errs++;
      $display("FAIL restart: got state=%0d s1=%0d s2=%0d w=%0d pr=%0d want 1 0 0 0 1",
               state, score1, score2, winner, pad_reset);
    end
  endtask

  task automatic test_midreset();
    step();
    ticks(60);
    miss(1'b0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    vecs++;
    if (state !== 3'd0 || score2 !== 4'd0 || ball_en !== 1'b0) begin
      errs++;
      $display("FAIL midreset: got state=%0d s2=%0d en=%0d want 0 0 0",
               state, score2, ball_en);
    end
  endtask

  initial begin
    reset = 1'b1; x = 10'd5; y = 10'd0; start = 1'b0;
    btn_up1 = 1'b0; btn_down1 = 1'b0; btn_up2 = 1'b0; btn_down2 = 1'b0;
    ai_mode = 1'b0; ball_y = 10'd0; pad2_t = 10'd0;
    miss_l = 1'b0; miss_r = 1'b0;
    test_reset();
    test_start();
    test_serve();
    test_miss();
    test_buttons();
    test_ai();
    test_point_gate();
    test_win();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
